uart_rx_fifo: RTL and testbench

//  Parametrised UART receiver with receive FIFO and per-byte error flags; successor to the single-byte Hack RX.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/uart_rx_fifo.sv | 159 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM encoding,
// out register bit positions and the baud divider helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam int OUT_EMPTY = 15;
    localparam int OUT_FERR  = 14;
    localparam int OUT_PERR  = 13;
    localparam int OUT_OVR   = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } rx_state_t;

    function automatic int div_of(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with synchronous reset.
// dout always shows the head entry; it is stale when empty.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot a simultaneous push needs when full
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-FF synchroniser, deframing FSM, per-byte
// error flags and a FWFT receive FIFO read through out.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 25000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int DEPTH     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx,
    input  logic                   rd,
    output logic [15:0]            out,
    output logic [$clog2(DEPTH):0] count
);

    localparam int DIV = div_of(CLK_HZ, BAUD);
    localparam int CW  = $clog2(DIV);
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [CW-1:0] FULL = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
    localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

    rx_state_t            state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bitn, bitn_n;
    logic [DATA_BITS-1:0] sh, sh_n;
    logic                 perr, perr_n;
    logic                 rx_m, rxs;
    logic                 tick, push;

    logic [9:0] wdata, head;
    logic       full, empty, pop_acc, ovr_set, ovr;

    assign tick = (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m  <= 1'b1;
            rxs   <= 1'b1;
            state <= S_IDLE;
            cnt   <= '0;
            bitn  <= '0;
            sh    <= '0;
            perr  <= 1'b0;
        end else begin
            rx_m  <= rx;
            rxs   <= rx_m;
            state <= state_n;
            cnt   <= cnt_n;
            bitn  <= bitn_n;
            sh    <= sh_n;
            perr  <= perr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bitn_n  = bitn;
        sh_n    = sh;
        perr_n  = perr;
        push    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!rxs) begin
                    state_n = S_START;
                    cnt_n   = HALF;
                end
            end
            S_START: begin
                if (!tick) begin
                    cnt_n = cnt - 1'b1;
                end else if (rxs) begin
                    state_n = S_IDLE;
                end else begin
                    state_n = S_DATA;
                    cnt_n   = FULL;
                    bitn_n  = '0;
                    perr_n  = 1'b0;
                end
            end
            S_DATA: begin
                if (!tick) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    sh_n   = {rxs, sh[DATA_BITS-1:1]};
                    bitn_n = bitn + 1'b1;
                    cnt_n  = FULL;
                    if (bitn == LAST)
                        state_n = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (!tick) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    perr_n  = rxs ^ (^sh) ^ (PARITY == PARITY_ODD);
                    cnt_n   = FULL;
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (!tick) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    push    = 1'b1;
                    state_n = rxs ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (rxs) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign wdata   = {~rxs, perr, 8'(sh)};
    assign pop_acc = rd && !empty;
    assign ovr_set = push && full && !pop_acc;

    sync_fifo #(
        .WIDTH (10),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (rd),
        .din   (wdata),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (reset)        ovr <= 1'b0;
        else if (ovr_set) ovr <= 1'b1;
        else if (pop_acc) ovr <= 1'b0;
    end

    always_comb begin
        out          = '0;
        out[OUT_OVR] = ovr;
        if (empty) begin
            out[OUT_EMPTY] = 1'b1;
        end else begin
            out[OUT_FERR] = head[9];
            out[OUT_PERR] = head[8];
            out[7:0]      = head[7:0];
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: default, even-parity
// and 4-deep instances driven with hand-timed serial frames.
module tb_uart_rx_fifo;

    localparam int DIV     = 217;
    localparam int OP_SEND = 0;
    localparam int OP_RD   = 1;

    logic        clk;
    logic        reset;
    logic        rx0, rx1, rx2;
    logic        rd0, rd1, rd2;
    logic [15:0] out0, out1, out2;
    logic [4:0]  cnt0, cnt1;
    logic [2:0]  cnt2;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int          op;
        int          tgt;
        logic [7:0]  data;
        logic        parb;
        logic [15:0] exp_out;
        int          exp_cnt;
    } vec_t;

    vec_t tbl [15];

    uart_rx_fifo u_def (
        .clk   (clk),
        .reset (reset),
        .rx    (rx0),
        .rd    (rd0),
        .out   (out0),
        .count (cnt0)
    );

    uart_rx_fifo #(.PARITY(1)) u_par (
        .clk   (clk),
        .reset (reset),
        .rx    (rx1),
        .rd    (rd1),
        .out   (out1),
        .count (cnt1)
    );

    uart_rx_fifo #(.DEPTH(4)) u_d4 (
        .clk   (clk),
        .reset (reset),
        .rx    (rx2),
        .rd    (rd2),
        .out   (out2),
        .count (cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want test end");
        $fatal(1);
    end

    task automatic set_rx(input int t, input logic v);
        case (t)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    task automatic set_rd(input int t, input logic v);
        case (t)
            0:       rd0 = v;
            1:       rd1 = v;
            default: rd2 = v;
        endcase
    endtask

    function automatic logic [15:0] get_out(input int t);
        case (t)
            0:       return out0;
            1:       return out1;
            default: return out2;
        endcase
    endfunction

    function automatic int get_cnt(input int t);
        case (t)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    task automatic check(input string nm, input logic [15:0] got,
                         input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, got, exp);
        end
    endtask

    task automatic check_state(input string nm, input int t,
                               input logic [15:0] eo, input int ec);
        check({nm, "_out"}, get_out(t), eo);
        check({nm, "_cnt"}, 16'(get_cnt(t)), 16'(ec));
    endtask

    task automatic send_frame(input int t, input logic [7:0] d,
                              input logic has_par, input logic pb,
                              input logic sb);
        @(posedge clk);
        #1 set_rx(t, 1'b0);
        repeat (DIV) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 set_rx(t, d[i]);
            repeat (DIV) @(posedge clk);
        end
        if (has_par) begin
            #1 set_rx(t, pb);
            repeat (DIV) @(posedge clk);
        end
        #1 set_rx(t, sb);
        repeat (DIV) @(posedge clk);
    endtask

    task automatic rd_pulse(input int t);
        @(posedge clk);
        #1 set_rd(t, 1'b1);
        @(posedge clk);
        #1 set_rd(t, 1'b0);
        @(negedge clk);
    endtask

    task automatic settle();
        repeat (20) @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input int op, input int t,
                                input logic [7:0] d, input logic pb,
                                input logic [15:0] eo, input int ec);
        vec_t v;
        v.op      = op;
        v.tgt     = t;
        v.data    = d;
        v.parb    = pb;
        v.exp_out = eo;
        v.exp_cnt = ec;
        return v;
    endfunction

    initial begin
        tbl[0]  = mk(OP_SEND, 0, 8'h55, 1'b0, 16'h0055, 1);
        tbl[1]  = mk(OP_RD,   0, 8'h00, 1'b0, 16'h8000, 0);
        tbl[2]  = mk(OP_SEND, 1, 8'h07, 1'b0, 16'h2007, 1);
        tbl[3]  = mk(OP_SEND, 1, 8'h07, 1'b1, 16'h2007, 2);
        tbl[4]  = mk(OP_RD,   1, 8'h00, 1'b0, 16'h0007, 1);
        tbl[5]  = mk(OP_RD,   1, 8'h00, 1'b0, 16'h8000, 0);
        tbl[6]  = mk(OP_SEND, 2, 8'h01, 1'b0, 16'h0001, 1);
        tbl[7]  = mk(OP_SEND, 2, 8'h02, 1'b0, 16'h0001, 2);
        tbl[8]  = mk(OP_SEND, 2, 8'h03, 1'b0, 16'h0001, 3);
        tbl[9]  = mk(OP_SEND, 2, 8'h04, 1'b0, 16'h0001, 4);
        tbl[10] = mk(OP_SEND, 2, 8'h05, 1'b0, 16'h1001, 4);
        tbl[11] = mk(OP_RD,   2, 8'h00, 1'b0, 16'h0002, 3);
        tbl[12] = mk(OP_RD,   2, 8'h00, 1'b0, 16'h0003, 2);
        tbl[13] = mk(OP_RD,   2, 8'h00, 1'b0, 16'h0004, 1);
        tbl[14] = mk(OP_RD,   2, 8'h00, 1'b0, 16'h8000, 0);

        reset = 1'b1;
        rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
        rd0 = 1'b0; rd1 = 1'b0; rd2 = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_state("rst_def", 0, 16'h8000, 0);
        check_state("rst_par", 1, 16'h8000, 0);
        check_state("rst_d4",  2, 16'h8000, 0);

        for (int i = 0; i < 15; i++) begin
            if (tbl[i].op == OP_SEND) begin
                send_frame(tbl[i].tgt, tbl[i].data, tbl[i].tgt == 1,
                           tbl[i].parb, 1'b1);
                settle();
            end else begin
                rd_pulse(tbl[i].tgt);
            end
            check_state($sformatf("vec%0d", i), tbl[i].tgt,
                        tbl[i].exp_out, tbl[i].exp_cnt);
        end

        // full FIFO: pop lands in the exact push cycle of the next frame
        for (int i = 0; i < 4; i++) begin
            send_frame(2, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b1);
            settle();
        end
        check_state("full_pre", 2, 16'h0010, 4);
        fork
            send_frame(2, 8'h14, 1'b0, 1'b0, 1'b1);
            begin
                @(posedge clk);
                repeat (2063) @(posedge clk);
                #1 rd2 = 1'b1;
                @(negedge clk);
                check("fullpop_before_cnt", 16'(cnt2), 16'd4);
                @(posedge clk);
                #1 rd2 = 1'b0;
                @(negedge clk);
                check_state("fullpop_after", 2, 16'h0011, 4);
            end
        join
        settle();
        rd_pulse(2);
        rd_pulse(2);
        rd_pulse(2);
        check_state("fullpop_last", 2, 16'h0014, 1);
        rd_pulse(2);
        check_state("fullpop_drain", 2, 16'h8000, 0);

        // bad stop bit followed by a held-low line
        send_frame(0, 8'hA3, 1'b0, 1'b0, 1'b0);
        repeat (5 * DIV) @(posedge clk);
        @(negedge clk);
        check_state("break", 0, 16'h40A3, 1);
        @(posedge clk);
        #1 rx0 = 1'b1;
        repeat (2 * DIV) @(posedge clk);
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
        settle();
        check_state("after_break", 0, 16'h40A3, 2);
        rd_pulse(0);
        check_state("after_break_rd", 0, 16'h0011, 1);
        rd_pulse(0);
        check_state("after_break_drain", 0, 16'h8000, 0);

        // short low glitch is rejected
        @(posedge clk);
        #1 rx0 = 1'b0;
        repeat (50) @(posedge clk);
        #1 rx0 = 1'b1;
        repeat (300) @(posedge clk);
        @(negedge clk);
        check_state("glitch", 0, 16'h8000, 0);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        settle();
        check_state("glitch_next", 0, 16'h003C, 1);
        rd_pulse(0);
        check_state("glitch_drain", 0, 16'h8000, 0);

        // reset in the middle of data bit 3
        send_frame(0, 8'h77, 1'b0, 1'b0, 1'b1);
        settle();
        check_state("prereset", 0, 16'h0077, 1);
        @(posedge clk);
        #1 rx0 = 1'b0;
        repeat (4 * DIV + DIV / 2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        rx0 = 1'b1;
        @(negedge clk);
        check_state("midreset", 0, 16'h8000, 0);
        repeat (3 * DIV) @(posedge clk);
        @(negedge clk);
        check_state("midreset_idle", 0, 16'h8000, 0);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        settle();
        check_state("midreset_next", 0, 16'h003C, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
